uart_tx_arbiter: RTL and testbench

UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

---
 rtl/uart_tx_arbiter.sv | 201 ++++++++++++++++++++
 tb/tb_uart_tx_arbiter.sv | 331 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter
// Shares one UART transmitter among N_REQ requesters. A round-robin pick in
// IDLE latches the winner's byte, fires a one-cycle start strobe, then follows
// the transmitter through busy / frame-complete handshakes. Each wait is
// bounded by a timeout. The owner receives a done pulse, with err when the
// frame timed out. Every output comes straight from a flop.

module uart_tx_arbiter #(
  parameter int N_REQ   = 4,
  parameter int TIMEOUT = 1000
) (
  input  logic                 clock,
  input  logic                 reset_n,
  input  logic [N_REQ-1:0]     req,
  input  logic [8*N_REQ-1:0]   req_data,
  output logic [N_REQ-1:0]     grant,
  output logic [N_REQ-1:0]     done,
  output logic                 err,
  output logic                 arb_busy,
  output logic                 tx_send,
  output logic [7:0]           tx_data,
  input  logic                 tx_busy,
  input  logic                 tx_sent
);

  localparam int IW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LAUNCH,
    S_WAIT_BUSY,
    S_WAIT_SENT,
    S_RELEASE,
    S_DRAIN
  } state_t;

  state_t             r_state;
  state_t             w_next;
  logic [15:0]        r_cnt;
  logic [IW-1:0]      r_last;
  logic [N_REQ-1:0]   r_grant;
  logic [N_REQ-1:0]   r_done;
  logic               r_err;
  logic               r_busy;
  logic               r_tx_send;
  logic [7:0]         r_tx_data;

  logic               w_found;
  logic [IW-1:0]      w_win;
  logic [N_REQ-1:0]   w_win_oh;
  logic [7:0]         w_win_byte;
  logic               w_cnt_hit;
  logic               w_timeout;
  logic               w_pick;

  assign grant    = r_grant;
  assign done     = r_done;
  assign err      = r_err;
  assign arb_busy = r_busy;
  assign tx_send  = r_tx_send;
  assign tx_data  = r_tx_data;

  // Round-robin search: first active request after the previous owner.
  // NOTE: every variable written in a combinational block gets a default at
  // the top, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    w_found = 1'b0;
    w_win   = r_last;
    for (int off = 1; off <= N_REQ; off++) begin
      if (!w_found && req[(int'(r_last) + off) % N_REQ]) begin
        w_found = 1'b1;
        w_win   = IW'((int'(r_last) + off) % N_REQ);
      end
    end
  end

  // Decode the winner into a one-hot grant vector and select its byte.
  always_comb begin
    w_win_oh   = '0;
    w_win_byte = 8'h00;
    for (int i = 0; i < N_REQ; i++) begin
      if (w_win == IW'(i)) begin
        w_win_oh[i] = 1'b1;
        w_win_byte  = req_data[8*i +: 8];
      end
    end
  end

  assign w_cnt_hit = (r_cnt == 16'(TIMEOUT - 1));

  // Next-state logic; w_timeout marks a RELEASE reached by the wait limit.
  always_comb begin
    w_next    = r_state;
    w_timeout = 1'b0;
    w_pick    = 1'b0;
    case (r_state)
      S_IDLE: begin
        // A frame-complete flag still standing from an earlier frame
        // (for example after a reset mid-frame) blocks arbitration.
        if (w_found && !tx_sent) begin
          w_next = S_LAUNCH;
          w_pick = 1'b1;
        end
      end
      S_LAUNCH: begin
        w_next = S_WAIT_BUSY;
      end
      S_WAIT_BUSY: begin
        if (tx_busy) begin
          w_next = S_WAIT_SENT;
        end else if (w_cnt_hit) begin
          w_next    = S_RELEASE;
          w_timeout = 1'b1;
        end
      end
      S_WAIT_SENT: begin
        if (tx_sent) begin
          w_next = S_RELEASE;
        end else if (w_cnt_hit) begin
          w_next    = S_RELEASE;
          w_timeout = 1'b1;
        end
      end
      S_RELEASE: begin
        w_next = S_DRAIN;
      end
      S_DRAIN: begin
        if (!tx_sent) begin
          w_next = S_IDLE;
        end
      end
      default: begin
        w_next = S_IDLE;
      end
    endcase
  end

  // State register.
  // NOTE: clocked state uses non-blocking assignments so every flop samples
  // the pre-edge values regardless of block evaluation order.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Wait counter: cleared when a wait state is entered, counts while in it.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_cnt <= 16'd0;
    end else if ((w_next != r_state) &&
                 ((w_next == S_WAIT_BUSY) || (w_next == S_WAIT_SENT))) begin
      r_cnt <= 16'd0;
    end else if ((r_state == S_WAIT_BUSY) || (r_state == S_WAIT_SENT)) begin
      r_cnt <= r_cnt + 16'd1;
    end
  end

  // Ownership and data latch: set on the pick, held until IDLE is re-entered.
  // tx_data is never touched mid-frame since the transmitter reads it live.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_grant   <= '0;
      r_tx_data <= 8'h00;
      r_last    <= IW'(N_REQ - 1);
    end else if (w_pick) begin
      r_grant   <= w_win_oh;
      r_tx_data <= w_win_byte;
      r_last    <= w_win;
    end else if (w_next == S_IDLE) begin
      r_grant   <= '0;
    end
  end

  // Registered strobes: each is high exactly while the FSM sits in its state.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_tx_send <= 1'b0;
      r_done    <= '0;
      r_err     <= 1'b0;
      r_busy    <= 1'b0;
    end else begin
      r_tx_send <= (w_next == S_LAUNCH);
      r_done    <= (w_next == S_RELEASE) ? r_grant : '0;
      r_err     <= (w_next == S_RELEASE) && w_timeout;
      r_busy    <= (w_next != S_IDLE);
    end
  end

  // Structural invariants of the arbiter.
  a_grant_onehot : assert property (@(posedge clock) disable iff (!reset_n)
    $onehot0(r_grant));
  a_send_in_launch : assert property (@(posedge clock) disable iff (!reset_n)
    r_tx_send |-> (r_state == S_LAUNCH));
  a_data_stable : assert property (@(posedge clock) disable iff (!reset_n)
    (r_state inside {S_WAIT_BUSY, S_WAIT_SENT, S_RELEASE, S_DRAIN})
      |-> $stable(r_tx_data));

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Self-checking bench for uart_tx_arbiter: a behavioural UART transmitter
// model, a directed vector table, hand sequences for the multi-cycle corners,
// and randomized batches checked against a round-robin service-order model.

module tb_uart_tx_arbiter;

  localparam int N   = 4;
  localparam int TMO = 64;
  localparam int CPB = 2;

  logic           clock    = 1'b0;
  logic           reset_n  = 1'b0;
  logic [N-1:0]   req      = '0;
  logic [8*N-1:0] req_data = '0;
  logic [N-1:0]   grant;
  logic [N-1:0]   done;
  logic           err;
  logic           arb_busy;
  logic           tx_send;
  logic [7:0]     tx_data;
  logic           tx_busy  = 1'b0;
  logic           tx_sent  = 1'b0;

  uart_tx_arbiter #(.N_REQ(N), .TIMEOUT(TMO)) dut (
    .clock    (clock),
    .reset_n  (reset_n),
    .req      (req),
    .req_data (req_data),
    .grant    (grant),
    .done     (done),
    .err      (err),
    .arb_busy (arb_busy),
    .tx_send  (tx_send),
    .tx_data  (tx_data),
    .tx_busy  (tx_busy),
    .tx_sent  (tx_sent)
  );

  always #5 clock = ~clock;

  int n_cmp  = 0;
  int n_fail = 0;
  int cyc    = 0;

  always @(posedge clock) cyc <= cyc + 1;

  // ---------------- UART transmitter model ----------------
  // Start bit, 8 data bits sampled live from tx_data LSB first, stop bit,
  // CPB clocks per bit; then tx_sent stays high for 3 clocks.
  bit         uart_dead  = 1'b0;
  bit         m_active   = 1'b0;
  int         m_tick     = 0;
  int         m_sent_cnt = 0;
  logic [7:0] m_byte     = 8'h00;

  always @(posedge clock) begin
    if (m_sent_cnt > 0) begin
      m_sent_cnt <= m_sent_cnt - 1;
      if (m_sent_cnt == 1) tx_sent <= 1'b0;
    end
    if (!m_active) begin
      if (tx_send && !uart_dead) begin
        m_active <= 1'b1;
        m_tick   <= 0;
        tx_busy  <= 1'b1;
      end
    end else begin
      m_tick <= m_tick + 1;
      if ((m_tick / CPB) >= 1 && (m_tick / CPB) <= 8 && (m_tick % CPB) == CPB - 1)
        m_byte[3'(m_tick / CPB - 1)] <= tx_data[3'(m_tick / CPB - 1)];
      if (m_tick == 10 * CPB - 1) begin
        m_active   <= 1'b0;
        tx_busy    <= 1'b0;
        tx_sent    <= 1'b1;
        m_sent_cnt <= 3;
      end
    end
  end

  // ---------------- monitors ----------------
  int         onehot_viol = 0;
  int         stab_viol   = 0;
  int         done_total  = 0;
  int         last_send   = -1;
  int         min_gap     = 1000000;
  logic [7:0] launch_byte = 8'h00;
  bit         scramble    = 1'b0;

  always @(negedge clock) begin
    if ($countones(grant) > 1) onehot_viol++;
    if (done != '0) done_total++;
    if (tx_send) begin
      if (last_send >= 0 && (cyc - last_send) < min_gap) min_gap = cyc - last_send;
      last_send   = cyc;
      launch_byte = tx_data;
    end else if (m_active && arb_busy && reset_n && tx_data != launch_byte) begin
      stab_viol++;
    end
    if (scramble) req_data = $urandom;
  end

  // ---------------- helpers ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual %0h required %0h", name, act, exp);
    end
  endtask

  logic [N-1:0] g_grant;
  logic [7:0]   g_txd;
  logic [N-1:0] g_done;
  logic         g_err;
  logic [7:0]   g_line;
  int           g_launch_cyc;
  int           g_done_cyc;

  task automatic wait_launch();
    bit found = 1'b0;
    for (int i = 0; i < 400 && !found; i++) begin
      @(negedge clock);
      if (tx_send) begin
        found        = 1'b1;
        g_grant      = grant;
        g_txd        = tx_data;
        g_launch_cyc = cyc;
      end
    end
    check("launch seen", 32'(found), 32'd1);
  endtask

  // Waits for done, then drops the served requester unless kept.
  task automatic wait_done(input logic [N-1:0] keep);
    bit found = 1'b0;
    for (int i = 0; i < 2000 && !found; i++) begin
      @(negedge clock);
      if (done != '0) begin
        found      = 1'b1;
        g_done     = done;
        g_err      = err;
        g_line     = m_byte;
        g_done_cyc = cyc;
        req        = req & (~done | keep);
      end
    end
    check("done seen", 32'(found), 32'd1);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, " grant"},    32'(grant),    32'h0);
    check({tag, " done"},     32'(done),     32'h0);
    check({tag, " err"},      32'(err),      32'h0);
    check({tag, " tx_send"},  32'(tx_send),  32'h0);
    check({tag, " tx_data"},  32'(tx_data),  32'h0);
    check({tag, " arb_busy"}, 32'(arb_busy), 32'h0);
  endtask

  // ---------------- directed table ----------------
  typedef struct {
    logic [N-1:0]   req;
    logic [8*N-1:0] data;
    logic [N-1:0]   exp_grant;
    logic [7:0]     exp_byte;
  } vec_t;

  vec_t tbl[6];
  int   m_last;
  int   exp_q[$];

  initial begin : main
    logic [7:0]   bytes4 [4];
    logic [N-1:0] mask;
    int           d0;
    bit           quiet;

    // Applied in order, starting with the previous owner = 3.
    tbl[0] = '{req: 4'b0010, data: 32'h3C7EA519, exp_grant: 4'b0010, exp_byte: 8'hA5};
    tbl[1] = '{req: 4'b1111, data: 32'h44332211, exp_grant: 4'b0100, exp_byte: 8'h33};
    tbl[2] = '{req: 4'b0011, data: 32'hDEADBEEF, exp_grant: 4'b0001, exp_byte: 8'hEF};
    tbl[3] = '{req: 4'b1000, data: 32'h80000001, exp_grant: 4'b1000, exp_byte: 8'h80};
    tbl[4] = '{req: 4'b0101, data: 32'h00FF00AA, exp_grant: 4'b0001, exp_byte: 8'hAA};
    tbl[5] = '{req: 4'b0110, data: 32'h12345678, exp_grant: 4'b0010, exp_byte: 8'h56};

    // Reset state
    repeat (3) @(negedge clock);
    check_reset_outputs("reset");
    reset_n = 1'b1;
    repeat (2) @(negedge clock);
    check("idle arb_busy", 32'(arb_busy), 32'h0);

    // All four together: served 0,1,2,3, each dropping its own request.
    bytes4 = '{8'h11, 8'h22, 8'h33, 8'h44};
    req_data = 32'h44332211;
    req = 4'b1111;
    for (int k = 0; k < 4; k++) begin
      wait_launch();
      check("all4 grant", 32'(g_grant), 32'(1 << k));
      wait_done('0);
      check("all4 done", 32'(g_done), 32'(1 << k));
      check("all4 err", 32'(g_err), 32'h0);
      check("all4 line", 32'(g_line), 32'(bytes4[k]));
    end

    // Directed table: one frame per entry, requests cleared at done.
    for (int t = 0; t < 6; t++) begin
      req_data = tbl[t].data;
      req      = tbl[t].req;
      wait_launch();
      check("tbl grant", 32'(g_grant), 32'(tbl[t].exp_grant));
      check("tbl tx_data", 32'(g_txd), 32'(tbl[t].exp_byte));
      wait_done('0);
      req = '0;
      check("tbl done", 32'(g_done), 32'(tbl[t].exp_grant));
      check("tbl err", 32'(g_err), 32'h0);
      check("tbl line", 32'(g_line), 32'(tbl[t].exp_byte));
    end

    // Fairness: req0 held, req2 raised once during the first frame.
    req_data = 32'h00C200C0;
    req = 4'b0001;
    wait_launch();
    check("fair g0", 32'(g_grant), 32'h1);
    req[2] = 1'b1;
    wait_done(4'b0001);
    check("fair d0", 32'(g_done), 32'h1);
    wait_launch();
    check("fair g1", 32'(g_grant), 32'h4);
    check("fair b1", 32'(g_txd), 32'hC2);
    wait_done(4'b0001);
    wait_launch();
    check("fair g2", 32'(g_grant), 32'h1);
    wait_done('0);
    check("fair d2", 32'(g_done), 32'h1);
    check("fair req dropped", 32'(req), 32'h0);

    // Data stability: req_data scrambled every cycle during the frame.
    req_data = 32'h1111115A;
    req = 4'b0001;
    wait_launch();
    check("stab tx_data", 32'(g_txd), 32'h5A);
    scramble = 1'b1;
    wait_done('0);
    scramble = 1'b0;
    check("stab line", 32'(g_line), 32'h5A);
    check("stab tx_data held", 32'(stab_viol), 32'h0);

    // Timeout: transmitter never answers.
    uart_dead = 1'b1;
    req_data = 32'h00007700;
    req = 4'b0010;
    wait_launch();
    check("tmo grant", 32'(g_grant), 32'h2);
    wait_done('0);
    check("tmo done", 32'(g_done), 32'h2);
    check("tmo err", 32'(g_err), 32'h1);
    check("tmo latency", 32'(g_done_cyc - g_launch_cyc), 32'(TMO + 1));
    repeat (4) @(negedge clock);
    check("tmo idle busy", 32'(arb_busy), 32'h0);
    check("tmo idle grant", 32'(grant), 32'h0);
    uart_dead = 1'b0;

    // Randomized batches against a service-order model.
    m_last = 1;
    for (int b = 0; b < 15; b++) begin
      mask = 4'($urandom_range(1, 15));
      req_data = $urandom;
      exp_q.delete();
      for (int off = 1; off <= N; off++)
        if (mask[(m_last + off) % N]) exp_q.push_back((m_last + off) % N);
      req = mask;
      while (exp_q.size() > 0) begin
        int e;
        e = exp_q.pop_front();
        wait_launch();
        check("rnd grant", 32'(g_grant), 32'(1 << e));
        check("rnd tx_data", 32'(g_txd), 32'(req_data[8*e +: 8]));
        wait_done('0);
        check("rnd done", 32'(g_done), 32'(1 << e));
        check("rnd err", 32'(g_err), 32'h0);
        check("rnd line", 32'(g_line), 32'(req_data[8*e +: 8]));
        m_last = e;
      end
    end

    // Reset during WAIT_SENT: no done, then normal service from index order.
    req_data = 32'h000000AB;
    req = 4'b0001;
    wait_launch();
    repeat (6) @(negedge clock);
    d0 = done_total;
    reset_n = 1'b0;
    req = '0;
    @(negedge clock);
    check_reset_outputs("midreset");
    repeat (2) @(negedge clock);
    reset_n = 1'b1;
    quiet = 1'b0;
    for (int i = 0; i < 200 && !quiet; i++) begin
      @(negedge clock);
      if (!m_active && !tx_sent && m_sent_cnt == 0) quiet = 1'b1;
    end
    check("midreset quiet", 32'(quiet), 32'h1);
    check("midreset no done", 32'(done_total - d0), 32'h0);
    check("midreset idle", 32'(arb_busy), 32'h0);
    req_data = 32'h003C0000;
    req = 4'b0100;
    wait_launch();
    check("post grant", 32'(g_grant), 32'h4);
    wait_done('0);
    check("post done", 32'(g_done), 32'h4);
    check("post err", 32'(g_err), 32'h0);
    check("post line", 32'(g_line), 32'h3C);

    // Global invariants.
    repeat (5) @(negedge clock);
    check("grant onehot", 32'(onehot_viol), 32'h0);
    check("launch spacing", 32'(min_gap > 10 * CPB), 32'h1);
    check("data stable all", 32'(stab_viol), 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
